// File: rtl/dmem_wbuf.sv
// rtl/dmem_wbuf.sv - data memory with in-order write buffer, store-to-load forwarding and drain-on-idle
// Optional: DMEM_WBUF_COALESCE_EN merges stores into a matching pending entry.
module dmem_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic                       MemRead,
  input  logic [31:0]                DataAdr,
  input  logic [31:0]                WriteData,
  output logic [31:0]                ReadData,
  output logic                       Stall,
  output logic                       Empty,
  output logic [$clog2(DEPTH):0]     BufCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] adrQ [DEPTH];
  logic [31:0]   datQ [DEPTH];
  logic [31:0]   ram  [2**AW];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic [AW-1:0] idx;
  logic          drain, alloc, coalHit;
  logic          fwdHit;
  logic [31:0]   fwdData;
  logic [PW-1:0] fwdSlot;
  logic          unusedBits;

  assign idx   = DataAdr[AW+1:2];
  assign drain = (count != '0) && !MemRead;

  // Walk oldest to youngest so the last match found is the youngest store.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    fwdSlot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (adrQ[head + PW'(i)] == idx)) begin
        fwdHit  = 1'b1;
        fwdData = datQ[head + PW'(i)];
        fwdSlot = head + PW'(i);
      end
    end
  end

`ifdef DMEM_WBUF_COALESCE_EN
  // A head entry leaving this edge cannot absorb the store; it must allocate.
  assign coalHit    = MemWrite && fwdHit && !(drain && (fwdSlot == head));
  assign unusedBits = ^{DataAdr[31:AW+2], DataAdr[1:0]};
`else
  assign coalHit    = 1'b0;
  assign unusedBits = ^{DataAdr[31:AW+2], DataAdr[1:0], fwdSlot};
`endif

  assign Stall    = MemWrite && (count == CW'(DEPTH)) && !coalHit;
  assign alloc    = MemWrite && !Stall && !coalHit;
  assign ReadData = fwdHit ? fwdData : ram[idx];
  assign Empty    = (count == '0);
  assign BufCount = count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc) begin
        adrQ[tail] <= idx;
        datQ[tail] <= WriteData;
        tail       <= tail + 1'b1;
      end
      if (coalHit) begin
        datQ[fwdSlot] <= WriteData;
      end
      if (drain) begin
        ram[adrQ[head]] <= datQ[head];
        head            <= head + 1'b1;
      end
      count <= count + CW'(alloc) - CW'(drain);
    end
  end

endmodule

// File: tb/tb_dmem_wbuf.sv
// tb/tb_dmem_wbuf.sv - scoreboard bench for dmem_wbuf
module tb_dmem_wbuf;

  localparam int DEPTH = 4;
  localparam int AW    = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead;
  logic [31:0] DataAdr, WriteData;
  logic [31:0] ReadData;
  logic        Stall, Empty;
  logic [$clog2(DEPTH):0] BufCount;

  dmem_wbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .DataAdr(DataAdr), .WriteData(WriteData), .ReadData(ReadData),
    .Stall(Stall), .Empty(Empty), .BufCount(BufCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  localparam int S_RD = 0, S_CNT = 1, S_EMP = 2, S_STL = 3;

  // Monitor: compares every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        S_RD:    act = ReadData;
        S_CNT:   act = 32'(BufCount);
        S_EMP:   act = {31'b0, Empty};
        default: act = {31'b0, Stall};
      endcase
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.v);
      end
    end
  end

  task automatic expect_v(input string n, input int s, input logic [31:0] v);
    exp_t e;
    e.name = n; e.sel = s; e.v = v;
    q.push_back(e);
  endtask

  task automatic step(input logic rst, input logic w, input logic r,
                      input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    reset = rst; MemWrite = w; MemRead = r; DataAdr = a; WriteData = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; DataAdr = '0; WriteData = '0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // reset state
    step(1, 0, 1, 200, 0);
    expect_v("reset_cnt", S_CNT, 0);
    expect_v("reset_empty", S_EMP, 1);
    expect_v("reset_stall", S_STL, 0);

    // single store, drain, forwarding then RAM
    step(1, 1, 0, 200, 32'h4585e600);
    expect_v("st1_stall", S_STL, 0);
    step(1, 0, 0, 200, 0);
    expect_v("st1_cnt1", S_CNT, 1);
    expect_v("st1_empty0", S_EMP, 0);
    expect_v("st1_fwd", S_RD, 32'h4585e600);
    step(1, 0, 1, 200, 0);
    expect_v("st1_cnt0", S_CNT, 0);
    expect_v("st1_ram", S_RD, 32'h4585e600);

    // fill to full with MemRead held, fifth store stalls
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 1, 204 + 4 * k, 32'h1000 + k);
      expect_v("fill_stall", S_STL, 0);
    end
    step(1, 1, 1, 220, 32'h1004);
    expect_v("full_stall", S_STL, 1);
    expect_v("full_cnt", S_CNT, 4);
    step(1, 1, 0, 220, 32'h1004);
    expect_v("full_stall_drain", S_STL, 1);
    step(1, 1, 0, 220, 32'h1004);
    expect_v("held_accept", S_STL, 0);
    expect_v("held_cnt", S_CNT, 3);
    step(1, 0, 0, 0, 0);
    expect_v("drain_cnt3", S_CNT, 3);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 204, 0);
    expect_v("drained_empty", S_EMP, 1);
    expect_v("ram_204", S_RD, 32'h1000);
    for (int k = 1; k < 5; k++) begin
      step(1, 0, 1, 204 + 4 * k, 0);
      expect_v("ram_order", S_RD, 32'h1000 + k);
    end

    // two stores to the same word
    step(1, 1, 1, 224, 32'h1);
    step(1, 1, 1, 224, 32'h2);
    step(1, 0, 1, 224, 0);
    expect_v("same_fwd", S_RD, 32'h2);
`ifdef DMEM_WBUF_COALESCE_EN
    expect_v("same_cnt", S_CNT, 1);
`else
    expect_v("same_cnt", S_CNT, 2);
`endif
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 224, 0);
    expect_v("same_ram", S_RD, 32'h2);
    expect_v("same_empty", S_EMP, 1);

    // simultaneous push and drain at count 2
    step(1, 1, 1, 228, 32'hA);
    step(1, 1, 1, 232, 32'hB);
    step(1, 1, 0, 236, 32'hC);
    expect_v("pd_cnt_before", S_CNT, 2);
    step(1, 0, 1, 228, 0);
    expect_v("pd_cnt_after", S_CNT, 2);
    expect_v("pd_ram_a", S_RD, 32'hA);
    step(1, 0, 1, 232, 0);
    expect_v("pd_fwd_b", S_RD, 32'hB);
    step(1, 0, 1, 236, 0);
    expect_v("pd_fwd_c", S_RD, 32'hC);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 232, 0);
    expect_v("pd_ram_b", S_RD, 32'hB);
    expect_v("pd_empty", S_EMP, 1);
    step(1, 0, 1, 236, 0);
    expect_v("pd_ram_c", S_RD, 32'hC);

    // reset discards pending entries, RAM retained; reset beats push/drain
    step(1, 1, 1, 224, 32'hDEAD0001);
    step(1, 1, 1, 228, 32'hDEAD0002);
    step(1, 1, 1, 232, 32'hDEAD0003);
    step(0, 1, 0, 224, 32'h55);
    expect_v("rst_pre_cnt", S_CNT, 3);
    step(1, 0, 0, 224, 0);
    expect_v("rst_cnt", S_CNT, 0);
    expect_v("rst_empty", S_EMP, 1);
    expect_v("rst_ram56", S_RD, 32'h2);
    step(1, 0, 1, 228, 0);
    expect_v("rst_ram57", S_RD, 32'hA);
    step(1, 0, 1, 232, 0);
    expect_v("rst_ram58", S_RD, 32'hB);

    // pointer wrap: alternating store/drain
    for (int k = 0; k < 3 * DEPTH; k++) begin
      step(1, 1, 1, 4 * k, 32'hC0DE0000 + k);
      expect_v("wrap_stall", S_STL, 0);
      step(1, 0, 0, 0, 0);
      expect_v("wrap_cnt", S_CNT, 1);
    end
    for (int k = 0; k < 3 * DEPTH; k++) begin
      step(1, 0, 1, 4 * k, 0);
      expect_v("wrap_ram", S_RD, 32'hC0DE0000 + k);
    end

    step(1, 0, 1, 0, 0);
    @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
